// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch front end driving an async-read ROM, with a
// registered instruction slot, redirect flush and halt-on-HALT_WORD.
module ifetch_unit #(
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] HALT_WORD = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic [31:0]       fetch_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_count;
  logic        r_valid;
  logic        w_acc;
  logic        w_ld;
  assign w_acc       = r_valid & instr_ready;
  assign w_ld        = ~r_valid | instr_ready;
  assign rom_addr    = r_pc[ADDR_W+1:2];
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = (r_state == HALT);
  assign fetch_count = r_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_acc) r_count <= r_count + 32'd1;
      if (r_state == RUN) begin
        if (redirect_valid) begin
          r_pc    <= {redirect_target[31:2], 2'b00};
          r_valid <= 1'b0;
        end else if (w_ld) begin
          r_instr    <= rom_data;
          r_instr_pc <= r_pc;
          r_valid    <= 1'b1;
          // the halt word is presented to decode but pc parks on it
          if (rom_data == HALT_WORD) r_state <= HALT;
          else r_pc <= r_pc + 32'd4;
        end
      end else if (w_acc) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios plus randomized run against a cycle-level
// reference model of the fetch rules.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] instr, instr_pc, fetch_count;
  logic        instr_valid, halted;
  logic        instr_ready = 1'b0;
  logic [31:0] rom [32];
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_pc, m_instr, m_ipc, m_count;
  logic        m_valid, m_halt;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted), .fetch_count(fetch_count)
  );

  // advance one clock: update the model from the inputs seen at the edge
  task automatic tick();
    logic [31:0] w;
    @(posedge clk);
    if (!rst_n) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_count = 0; m_valid = 0; m_halt = 0;
    end else begin
      if (m_valid && instr_ready) m_count = m_count + 1;
      if (m_halt) begin
        if (instr_ready) m_valid = 0;
      end else if (redirect_valid) begin
        m_pc = redirect_target & ~32'd3;
        m_valid = 0;
      end else if (!m_valid || instr_ready) begin
        w = rom[(m_pc / 4) % 32];
        m_instr = w; m_ipc = m_pc; m_valid = 1;
        if (w == 0) m_halt = 1;
        else m_pc = m_pc + 4;
      end
    end
    #1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 32; i++) rom[i] = $urandom | 32'h100;
    rom[0] = 32'h34630010; rom[1] = 32'hac030000; rom[2] = 32'hac000004;
  endtask

  task automatic restart();
    rst_n = 0; redirect_valid = 0; tick(); rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; instr_ready = 1; tick(); tick();
    n_tests++;
    if (instr_valid !== 0 || instr !== 0 || instr_pc !== 0 || halted !== 0 || fetch_count !== 0 || rom_addr !== 0) begin
      n_fail++;
      $display("FAIL reset: valid=%b instr=%h pc=%h halted=%b cnt=%0d addr=%0d, want all zero", instr_valid, instr, instr_pc, halted, fetch_count, rom_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'h34630010; exp_i[1] = 32'hac030000; exp_i[2] = 32'hac000004;
    instr_ready = 1; restart();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1 || instr !== exp_i[k] || instr_pc !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL stream%0d: got v=%b %h@%h want 1 %h@%h", k, instr_valid, instr, instr_pc, exp_i[k], 4 * k);
      end
    end
    tick();
    n_tests++;
    if (fetch_count !== 3) begin
      n_fail++; $display("FAIL stream_count: got %0d want 3", fetch_count);
    end
  endtask

  task automatic test_stall();
    instr_ready = 1; restart(); tick(); tick();
    instr_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1 || instr !== 32'hac030000 || instr_pc !== 4 || rom_addr !== 2) begin
        n_fail++;
        $display("FAIL stall%0d: got v=%b %h@%h addr=%0d want 1 ac030000@4 addr=2", k, instr_valid, instr, instr_pc, rom_addr);
      end
    end
    instr_ready = 1; tick();
    n_tests++;
    if (instr_pc !== 8 || instr !== 32'hac000004) begin
      n_fail++; $display("FAIL stall_resume: got %h@%h want ac000004@8", instr, instr_pc);
    end
    tick();
    n_tests++;
    if (instr_pc !== 32'hc || fetch_count !== 3) begin
      n_fail++; $display("FAIL stall_next: got pc=%h cnt=%0d want c 3", instr_pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1; restart();
    for (int k = 0; k < 6; k++) tick();
    n_tests++;
    if (instr_pc !== 32'h14 || instr_valid !== 1) begin
      n_fail++; $display("FAIL redir_pre: got pc=%h v=%b want 14 1", instr_pc, instr_valid);
    end
    redirect_valid = 1; redirect_target = 32'h13; tick(); redirect_valid = 0;
    n_tests++;
    if (instr_valid !== 0 || rom_addr !== 4) begin
      n_fail++; $display("FAIL redir_bubble: got v=%b addr=%0d want 0 4", instr_valid, rom_addr);
    end
    tick();
    n_tests++;
    if (instr_valid !== 1 || instr_pc !== 32'h10 || instr !== rom[4]) begin
      n_fail++; $display("FAIL redir_target: got v=%b %h@%h want 1 %h@10", instr_valid, instr, instr_pc, rom[4]);
    end
  endtask

  task automatic test_halt();
    int cyc;
    rom[24] = 0; instr_ready = 1; restart();
    cyc = 0;
    while (!(instr_valid === 1 && instr_pc === 32'h60) && cyc < 40) begin
      n_tests++;
      if (halted !== 0) begin
        n_fail++; $display("FAIL halt_early: halted=%b at pc=%h want 0", halted, instr_pc);
      end
      tick(); cyc++;
    end
    n_tests++;
    if (cyc != 25 || instr !== 0) begin
      n_fail++; $display("FAIL halt_reach: got %0d cycles instr=%h want 25 0", cyc, instr);
    end
    tick();
    n_tests++;
    if (halted !== 1 || instr_valid !== 0 || fetch_count !== 25) begin
      n_fail++; $display("FAIL halt_accept: got h=%b v=%b cnt=%0d want 1 0 25", halted, instr_valid, fetch_count);
    end
    redirect_valid = 1; redirect_target = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (instr_valid !== 0 || rom_addr !== 24 || halted !== 1) begin
        n_fail++; $display("FAIL halt_redir: got v=%b addr=%0d h=%b want 0 24 1", instr_valid, rom_addr, halted);
      end
    end
    redirect_valid = 0; rom[24] = 32'h0badf00d;
  endtask

  task automatic test_wrap();
    rom[31] = 32'h11111111; instr_ready = 1; restart(); tick();
    redirect_valid = 1; redirect_target = 32'h7c; tick(); redirect_valid = 0;
    tick();
    n_tests++;
    if (instr_pc !== 32'h7c || instr !== 32'h11111111) begin
      n_fail++; $display("FAIL wrap_7c: got %h@%h want 11111111@7c", instr, instr_pc);
    end
    tick();
    n_tests++;
    if (instr_pc !== 32'h80 || instr !== 32'h34630010 || rom_addr !== 1) begin
      n_fail++; $display("FAIL wrap_80: got %h@%h addr=%0d want 34630010@80 addr=1", instr, instr_pc, rom_addr);
    end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1; restart();
    for (int k = 0; k < 8; k++) tick();
    instr_ready = 0; tick();
    n_tests++;
    if (fetch_count !== 7 || instr_valid !== 1) begin
      n_fail++; $display("FAIL rmid_pre: got cnt=%0d v=%b want 7 1", fetch_count, instr_valid);
    end
    rst_n = 0; tick(); rst_n = 1;
    n_tests++;
    if (instr_valid !== 0 || instr !== 0 || instr_pc !== 0 || halted !== 0 || fetch_count !== 0 || rom_addr !== 0) begin
      n_fail++;
      $display("FAIL rmid_reset: v=%b instr=%h pc=%h h=%b cnt=%0d addr=%0d want zeros", instr_valid, instr, instr_pc, halted, fetch_count, rom_addr);
    end
    instr_ready = 1; tick();
    n_tests++;
    if (instr_valid !== 1 || instr_pc !== 0 || instr !== 32'h34630010) begin
      n_fail++; $display("FAIL rmid_restart: got v=%b %h@%h want 1 34630010@0", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 32; i++) rom[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
    instr_ready = 1; restart();
    for (int c = 0; c < 3000; c++) begin
      instr_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 7) == 0;
      redirect_target = $urandom;
      rst_n = $urandom_range(0, 199) != 0;
      tick();
      n_tests++;
      if (instr_valid !== m_valid || halted !== m_halt || fetch_count !== m_count || rom_addr !== m_pc[6:2] || instr !== m_instr || instr_pc !== m_ipc) begin
        n_fail++;
        $display("FAIL random c%0d: got v=%b h=%b cnt=%0d addr=%0d %h@%h want v=%b h=%b cnt=%0d addr=%0d %h@%h", c, instr_valid, halted, fetch_count, rom_addr, instr, instr_pc, m_valid, m_halt, m_count, m_pc[6:2], m_instr, m_ipc);
      end
    end
    rst_n = 1; redirect_valid = 0;
  endtask

  initial begin
    fill_rom();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
